// File: rtl/adc_channel_sequencer.sv
// Scans enabled ADC channels once per sample period, requests conversions and tags returned samples.
// Optional ADC_SEQ_AVG_EN: four conversions per channel, averaged (truncated) before output.
module adc_channel_sequencer #(
  parameter int SAMPLE_PERIOD  = 50000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GUARD_CYCLES   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [7:0]  i_chan_mask,
  input  logic        i_unipolar,
  output logic [5:0]  o_tx_bits,
  output logic        o_convert_en,
  input  logic        i_rx_dv,
  input  logic [11:0] i_rx_data,
  output logic        o_sample_dv,
  output logic [2:0]  o_sample_chan,
  output logic [11:0] o_sample_data,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic [2:0]  o_state
);

  localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_DV = 3'd3,
    EMIT    = 3'd4,
    GUARD   = 3'd5
  } state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic          tick;
  logic [3:0]    ptr;
  logic [2:0]    chan;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] guard_cnt;
  logic          more_conv;

  assign o_state = state;

  // Handshake: o_convert_en is a single-cycle request; i_rx_dv is a single-cycle
  // response accepted only in WAIT_DV; o_sample_dv qualifies chan/data for one cycle.
  function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic uni);
    return {1'b1, c[0], c[2], c[1], uni, 1'b0};
  endfunction

  assign tick = i_enable && (period_cnt == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          period_cnt <= '0;
    else if (!i_enable) period_cnt <= '0;
    else if (tick)      period_cnt <= '0;
    else                period_cnt <= period_cnt + 1'b1;
  end

`ifdef ADC_SEQ_AVG_EN
  logic [13:0] acc;
  logic [13:0] acc_sum;
  logic [1:0]  conv_idx;
  assign acc_sum   = acc + {2'b00, i_rx_data};
  assign more_conv = (conv_idx != 2'd0);
`else
  assign more_conv = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      chan          <= '0;
      to_cnt        <= '0;
      guard_cnt     <= '0;
      o_tx_bits     <= '0;
      o_convert_en  <= 1'b0;
      o_sample_dv   <= 1'b0;
      o_sample_chan <= '0;
      o_sample_data <= '0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc           <= '0;
      conv_idx      <= '0;
`endif
    end else begin
      o_convert_en <= 1'b0;
      o_sample_dv  <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && (i_chan_mask != 8'd0)) begin
            state  <= SCAN;
            ptr    <= '0;
            o_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (!i_enable || ptr[3]) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_chan_mask[ptr[2:0]]) begin
            chan         <= ptr[2:0];
            o_tx_bits    <= cfg_word(ptr[2:0], i_unipolar);
            o_convert_en <= 1'b1;
            to_cnt       <= '0;
            state        <= ISSUE;
`ifdef ADC_SEQ_AVG_EN
            acc          <= '0;
            conv_idx     <= '0;
`endif
          end else begin
            ptr <= ptr + 4'd1;
          end
        end
        ISSUE: begin
          // The timeout window is measured from the request cycle itself.
          to_cnt <= to_cnt + 1'b1;
          state  <= WAIT_DV;
        end
        WAIT_DV: begin
          if (i_rx_dv) begin
`ifdef ADC_SEQ_AVG_EN
            if (conv_idx == 2'd3) begin
              o_sample_dv   <= 1'b1;
              o_sample_chan <= chan;
              o_sample_data <= acc_sum[13:2];
              conv_idx      <= '0;
              state         <= EMIT;
            end else begin
              acc       <= acc_sum;
              conv_idx  <= conv_idx + 2'd1;
              guard_cnt <= '0;
              state     <= GUARD;
            end
`else
            o_sample_dv   <= 1'b1;
            o_sample_chan <= chan;
            o_sample_data <= i_rx_data;
            state         <= EMIT;
`endif
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_timeout_err <= 1'b1;
            guard_cnt     <= '0;
            state         <= GUARD;
`ifdef ADC_SEQ_AVG_EN
            conv_idx      <= '0;
`endif
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EMIT: begin
          guard_cnt <= '0;
          state     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            if (more_conv) begin
              o_tx_bits    <= cfg_word(chan, i_unipolar);
              o_convert_en <= 1'b1;
              to_cnt       <= '0;
              state        <= ISSUE;
            end else if ((chan == 3'd7) || !i_enable) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              ptr   <= {1'b0, chan} + 4'd1;
              state <= SCAN;
            end
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
